// File: rtl/sd_access_arbiter.sv
// Two-port round-robin arbiter in front of a single SPI SD controller.
// Sequences the rd/wr/ready handshake, holds the sector address, and aborts hung transfers.

module sd_port_lane (
  input  logic gnt,
  input  logic we,
  input  logic byte_av,
  input  logic next_byte,
  input  logic done_any,
  output logic rvalid,
  output logic wnext,
  output logic done
);
  assign rvalid = gnt & ~we & byte_av;
  assign wnext  = gnt &  we & next_byte;
  assign done   = gnt & done_any;
endmodule

module sd_access_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd5_000_000,
  parameter int          RST_PULSE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [7:0]  p0_wdata,
  input  logic [7:0]  p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_wnext,
  output logic        p1_wnext,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [7:0]  rdata,
  output logic        p0_done,
  output logic        p1_done,
  output logic        err,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_address,
  output logic [7:0]  sd_din,
  output logic        sd_reset,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic        sd_ready_for_next_byte,
  input  logic [7:0]  sd_dout
);

  localparam int NUM_PORTS = 2;
  localparam int RW = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [9:0]    SECTOR_BYTES = 10'd512;

  typedef enum logic [2:0] {
    WAIT_INIT, IDLE, ISSUE, WAIT_START, XFER, DONE, ABORT
  } state_t;

  state_t state, state_nx;

  logic [NUM_PORTS-1:0]       req, p_we, gnt, rvalid, wnext, done;
  logic [NUM_PORTS-1:0][31:0] p_addr;
  logic [NUM_PORTS-1:0][7:0]  p_wdata;

  logic          we_q, last_grant, pick;
  logic [9:0]    byte_cnt;
  logic [23:0]   wd_cnt;
  logic [RW-1:0] rst_cnt;
  logic          timeout, done_any;

  assign req     = {p1_req, p0_req};
  assign p_we    = {p1_we, p0_we};
  assign p_addr  = {p1_addr, p0_addr};
  assign p_wdata = {p1_wdata, p0_wdata};

  // On a tie the port that did not win last time goes next.
  always_comb begin
    if (req[0] && req[1]) pick = ~last_grant;
    else                  pick = req[1];
  end

  // Watchdog allows TIMEOUT_CYCLES cycles across WAIT_START+XFER.
  assign timeout = (wd_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_INIT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sd_rd    = 1'b0;
    sd_wr    = 1'b0;
    sd_reset = 1'b0;
    done_any = 1'b0;
    err      = 1'b0;
    case (state)
      WAIT_INIT:  if (sd_ready) state_nx = IDLE;
      IDLE:       if (|req) state_nx = ISSUE;
      ISSUE: begin
        if (sd_ready) begin
          sd_rd    = ~we_q;
          sd_wr    = we_q;
          state_nx = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!sd_ready)    state_nx = XFER;
        else if (timeout) state_nx = ABORT;
      end
      XFER: begin
        if (sd_ready)     state_nx = DONE;
        else if (timeout) state_nx = ABORT;
      end
      DONE: begin
        done_any = 1'b1;
        err      = ~we_q & (byte_cnt != SECTOR_BYTES);
        state_nx = IDLE;
      end
      ABORT: begin
        sd_reset = 1'b1;
        done_any = (rst_cnt == '0);
        err      = (rst_cnt == '0);
        if (rst_cnt == RST_LAST) state_nx = WAIT_INIT;
      end
      default: state_nx = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt        <= '0;
      we_q       <= 1'b0;
      last_grant <= 1'b1;
      sd_address <= '0;
      byte_cnt   <= '0;
      wd_cnt     <= '0;
      rst_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt        <= pick ? 2'b10 : 2'b01;
            we_q       <= p_we[pick];
            sd_address <= p_addr[pick];
            last_grant <= pick;
            byte_cnt   <= '0;
          end
        end
        ISSUE:      wd_cnt <= '0;
        WAIT_START: wd_cnt <= wd_cnt + 24'd1;
        XFER: begin
          wd_cnt <= wd_cnt + 24'd1;
          if (sd_byte_available && !we_q) byte_cnt <= byte_cnt + 10'd1;
        end
        DONE: gnt <= '0;
        ABORT: begin
          gnt     <= '0;
          rst_cnt <= (rst_cnt == RST_LAST) ? '0 : rst_cnt + RW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    sd_port_lane u_lane (
      .gnt       (gnt[i]),
      .we        (we_q),
      .byte_av   (sd_byte_available),
      .next_byte (sd_ready_for_next_byte),
      .done_any  (done_any),
      .rvalid    (rvalid[i]),
      .wnext     (wnext[i]),
      .done      (done[i])
    );
  end

  always_comb begin
    sd_din = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (gnt[i]) sd_din = p_wdata[i];
  end

  assign rdata     = (|gnt) ? sd_dout : 8'h00;
  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_wnext  = wnext[0];
  assign p1_wnext  = wnext[1];
  assign p0_done   = done[0];
  assign p1_done   = done[1];

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Scoreboard bench for sd_access_arbiter with a behavioural SD controller model.

module tb_sd_access_arbiter;

  localparam logic [23:0] TO = 24'd1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [31:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_wnext, p1_wnext, p0_rvalid, p1_rvalid;
  logic [7:0]  rdata;
  logic        p0_done, p1_done, err, sd_rd, sd_wr, sd_reset;
  logic [31:0] sd_address;
  logic [7:0]  sd_din, sd_dout;
  logic        sd_ready, sd_byte_available, sd_ready_for_next_byte;

  sd_access_arbiter #(.TIMEOUT_CYCLES(TO), .RST_PULSE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_wnext(p0_wnext), .p1_wnext(p1_wnext),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid), .rdata(rdata),
    .p0_done(p0_done), .p1_done(p1_done), .err(err),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_address(sd_address), .sd_din(sd_din),
    .sd_reset(sd_reset), .sd_ready(sd_ready), .sd_byte_available(sd_byte_available),
    .sd_ready_for_next_byte(sd_ready_for_next_byte), .sd_dout(sd_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          err;
    int          r0, r1, w0, w1;
    logic [31:0] addr;
    bit          wr;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, issue_cnt = 0, issue_cyc = 0, rst_rise = 0, rst_len = 0;
  int r0 = 0, r1 = 0, w0 = 0, w1 = 0;
  int din_bad = 0, gate_bad = 0, rd_bad = 0, issue_bad = 0, err_alone = 0;
  bit rst_prev = 0, cap_wr = 0;
  logic [31:0] cap_addr = '0;

  int m_nbytes = 512;
  bit m_hang = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) break;
    end
    if (i == budget) chk("wait_done", done_cnt, target);
  endtask

  // Controller model: ready drops after issue, bytes stream, ready rises again.
  initial begin : ctrl_model
    bit wr;
    sd_ready = 0; sd_byte_available = 0; sd_ready_for_next_byte = 0; sd_dout = 0;
    repeat (100) @(negedge clk);
    sd_ready = 1;
    forever begin
      @(negedge clk);
      if (reset_n && (sd_rd || sd_wr)) begin
        wr = sd_wr;
        @(negedge clk); sd_ready = 0;
        if (m_hang) begin
          for (int i = 0; i < 5000 && !sd_reset; i++) @(negedge clk);
          for (int i = 0; i < 50 && sd_reset; i++) @(negedge clk);
          repeat (20) @(negedge clk);
          sd_ready = 1;
        end else begin
          repeat (2) @(negedge clk);
          for (int i = 0; i < m_nbytes; i++) begin
            if (wr) sd_ready_for_next_byte = 1;
            else begin sd_byte_available = 1; sd_dout = i[7:0]; end
            @(negedge clk);
          end
          sd_byte_available = 0; sd_ready_for_next_byte = 0;
          repeat (2) @(negedge clk);
          sd_ready = 1;
        end
      end
    end
  end

  initial begin : wdata_drv
    p0_wdata = 0; p1_wdata = 0;
    forever begin
      @(posedge clk); #2;
      p0_wdata = 8'($urandom); p1_wdata = 8'($urandom);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (reset_n) begin
      r0 += int'(p0_rvalid); r1 += int'(p1_rvalid);
      w0 += int'(p0_wnext);  w1 += int'(p1_wnext);
      if (sd_rd || sd_wr) begin
        issue_cnt++; issue_cyc = cyc; cap_addr = sd_address; cap_wr = sd_wr;
        if (!sd_ready) issue_bad++;
      end
      if (sd_reset) begin
        rst_len++;
        if (!rst_prev) rst_rise = cyc;
      end
      rst_prev = sd_reset;
      if (p1_gnt ? (sd_din !== p1_wdata) : p0_gnt ? (sd_din !== p0_wdata) : (sd_din !== 8'h00)) din_bad++;
      if ((p0_rvalid && !p0_gnt) || (p1_rvalid && !p1_gnt) ||
          (p0_wnext && !p0_gnt) || (p1_wnext && !p1_gnt)) gate_bad++;
      if ((p0_rvalid || p1_rvalid) && rdata !== sd_dout) rd_bad++;
      if (err && !(p0_done || p1_done)) err_alone++;
      if (p0_done || p1_done) begin
        done_cnt++;
        if (sb.size() == 0) chk("sb_pop", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("done_port", p1_done, e.port);
          chk("done_both", p0_done & p1_done, 0);
          chk("err", err, e.err);
          chk("rvalid0_cnt", r0, e.r0);
          chk("rvalid1_cnt", r1, e.r1);
          chk("wnext0_cnt", w0, e.w0);
          chk("wnext1_cnt", w1, e.w1);
          chk("issue_addr", cap_addr, e.addr);
          chk("addr_hold", sd_address, e.addr);
          chk("issue_we", cap_wr, e.wr);
        end
        r0 = 0; r1 = 0; w0 = 0; w1 = 0;
      end
    end
  end

  initial begin : stim
    int gsum;
    bit seen;
    reset_n = 0;
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0; p0_addr = 0; p1_addr = 0;

    // Read on p0 requested before the card is ready
    p0_addr = 32'h0000_2940;
    sb.push_back('{0, 0, 512, 0, 0, 0, 32'h0000_2940, 0});
    p0_req = 1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {p0_gnt, p1_gnt, p0_done, p1_done, err, sd_rd, sd_wr, sd_reset, sd_din}, 0);
    chk("rst_addr", sd_address, 0);
    reset_n = 1;
    repeat (80) @(negedge clk);
    chk("pre_init_issue", issue_cnt, 0);
    chk("pre_init_gnt", p0_gnt, 0);
    wait_done(1, 2000);
    p0_req = 0;

    // p1 sector write
    p1_we = 1; p1_addr = 32'h0000_ABCD;
    sb.push_back('{1, 0, 0, 0, 0, 512, 32'h0000_ABCD, 1});
    p1_req = 1;
    wait_done(2, 2000);
    p1_req = 0; p1_we = 0;

    // Simultaneous requests alternate, starting with p0 (p1 won last)
    p0_addr = 32'h0000_1000; p1_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++)
      sb.push_back('{k[0], 0, k[0] ? 0 : 512, k[0] ? 512 : 0, 0, 0,
                     k[0] ? 32'h0000_2000 : 32'h0000_1000, 0});
    p0_req = 1; p1_req = 1;
    wait_done(6, 6000);
    p0_req = 0; p1_req = 0;

    // Short read: 500 bytes
    m_nbytes = 500; p0_addr = 32'h0000_0500;
    sb.push_back('{0, 1, 500, 0, 0, 0, 32'h0000_0500, 0});
    p0_req = 1;
    wait_done(7, 2000);
    p0_req = 0; m_nbytes = 512;

    // Controller hangs: watchdog abort
    m_hang = 1; p0_addr = 32'h0000_0777;
    sb.push_back('{0, 1, 0, 0, 0, 0, 32'h0000_0777, 0});
    p0_req = 1;
    wait_done(8, 3000);
    p0_req = 0; m_hang = 0;
    chk("timeout_latency", rst_rise - issue_cyc, int'(TO) + 1);
    p1_addr = 32'h0000_0888;
    sb.push_back('{1, 0, 0, 512, 0, 0, 32'h0000_0888, 0});
    p1_req = 1;
    gsum = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); gsum += int'(p1_gnt) + int'(p0_gnt); end
    chk("gnt_during_reinit", gsum, 0);
    wait_done(9, 2000);
    p1_req = 0;
    chk("rst_pulse_len", rst_len, 4);

    // Async reset in the middle of a read
    p0_addr = 32'h0000_0999;
    p0_req = 1;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin @(negedge clk); seen = p0_rvalid; end
    chk("xfer_seen", seen, 1);
    #3 reset_n = 0;
    #1;
    chk("async_rst_outs", {p0_gnt, p1_gnt, p0_wnext, p1_wnext, p0_rvalid, p1_rvalid, rdata,
                           p0_done, p1_done, err, sd_rd, sd_wr, sd_din, sd_reset}, 0);
    chk("async_rst_addr", sd_address, 0);

    chk("din_mux", din_bad, 0);
    chk("strobe_gate", gate_bad, 0);
    chk("rdata_pass", rd_bad, 0);
    chk("issue_wo_ready", issue_bad, 0);
    chk("err_wo_done", err_alone, 0);
    chk("sb_left", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
